thread_reg_loader: RTL and testbench

THREAD_REG_LOADER -- requirements
Module: thread_reg_loader

---
 rtl/thread_reg_loader.sv | 178 +++++++++++++++++
 tb/tb_thread_reg_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thread_reg_loader.sv
// -----------------------------------------------------------------------------
// thread_reg_loader
//   Collects a serial stream of 32-bit words into a 16-word thread frame and
//   commits it to the thread register file with a one-cycle RegWrite strobe.
//   After the commit the loader holds off for GAP_CYCLES cycles. It then pulses
//   Done and returns to IDLE.
//
// Ports
//   Clk, Rst_n              clock / async active-low reset
//   Start                   begin a new frame (honoured in IDLE only)
//   Abort                   cancel a fill in progress (honoured in FILL only)
//   InData, InValid         serial word stream
//   InReady                 stream handshake, high in FILL
//   WriteData1..16          parallel frame, WriteDataN = Nth accepted word
//   RegWrite                one-cycle commit strobe (COMMIT state)
//   Done                    one-cycle pulse after the post-commit gap
//   Busy                    high in every state except IDLE
//   WordCount               words accepted in the current frame (0..16)
// -----------------------------------------------------------------------------

// One frame word. Written only when the loader selects this lane.
module thread_reg_slot #(
  parameter int VEC_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             i_we,
  input  logic [VEC_W-1:0] i_d,
  output logic [VEC_W-1:0] o_q
);
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)    o_q <= '0;
    else if (i_we) o_q <= i_d;
  end
endmodule

module thread_reg_loader #(
  parameter int GAP_CYCLES = 1   // 0..7
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic        Abort,
  input  logic [31:0] InData,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] WriteData1,
  output logic [31:0] WriteData2,
  output logic [31:0] WriteData3,
  output logic [31:0] WriteData4,
  output logic [31:0] WriteData5,
  output logic [31:0] WriteData6,
  output logic [31:0] WriteData7,
  output logic [31:0] WriteData8,
  output logic [31:0] WriteData9,
  output logic [31:0] WriteData10,
  output logic [31:0] WriteData11,
  output logic [31:0] WriteData12,
  output logic [31:0] WriteData13,
  output logic [31:0] WriteData14,
  output logic [31:0] WriteData15,
  output logic [31:0] WriteData16,
  output logic        RegWrite,
  output logic        Done,
  output logic        Busy,
  output logic [4:0]  WordCount
);

  localparam int NUM_LANES = 16;
  localparam int VEC_W     = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_COMMIT = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t                             r_state;
  logic [4:0]                         r_count;
  logic [2:0]                         r_gap_cnt;
  logic                               r_done;

  logic                               w_xfer;
  logic [NUM_LANES-1:0]               w_we;
  logic [NUM_LANES-1:0][VEC_W-1:0]    w_frame;

  // InReady is decoded from state, so a transfer is simply FILL && InValid.
  // A word arriving together with Abort is dropped.
  assign w_xfer = (r_state == S_FILL) && InValid && !Abort;

  // Lane select: the word goes to the slot indexed by the current count.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_we
    assign w_we[g] = w_xfer && (r_count == 5'(g));
  end

  thread_reg_slot #(.VEC_W(VEC_W)) u_slot [NUM_LANES-1:0] (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .i_we  (w_we),
    .i_d   ({NUM_LANES{InData}}),
    .o_q   (w_frame)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_gap_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Start wins over a coincident Abort here.
          if (Start) begin
            r_state <= S_FILL;
            r_count <= '0;
          end
        end
        S_FILL: begin
          if (Abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (InValid) begin
            r_count <= r_count + 5'd1;
            if (r_count == 5'd15) r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_gap_cnt <= '0;
          if (GAP_CYCLES == 0) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (int'(r_gap_cnt) >= GAP_CYCLES - 1) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_done  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs are flop-driven or decoded from the state register only.
  assign InReady   = (r_state == S_FILL);
  assign RegWrite  = (r_state == S_COMMIT);
  assign Busy      = (r_state != S_IDLE);
  assign Done      = r_done;
  assign WordCount = r_count;

  assign WriteData1  = w_frame[0];
  assign WriteData2  = w_frame[1];
  assign WriteData3  = w_frame[2];
  assign WriteData4  = w_frame[3];
  assign WriteData5  = w_frame[4];
  assign WriteData6  = w_frame[5];
  assign WriteData7  = w_frame[6];
  assign WriteData8  = w_frame[7];
  assign WriteData9  = w_frame[8];
  assign WriteData10 = w_frame[9];
  assign WriteData11 = w_frame[10];
  assign WriteData12 = w_frame[11];
  assign WriteData13 = w_frame[12];
  assign WriteData14 = w_frame[13];
  assign WriteData15 = w_frame[14];
  assign WriteData16 = w_frame[15];

endmodule

// File: tb/tb_thread_reg_loader.sv
module tb_thread_reg_loader;

  typedef logic [15:0][31:0] frame_t;

  localparam int GAPS [3] = '{1, 0, 7};

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Start_aux = 1'b0;
  logic        Abort = 1'b0;
  logic        InValid = 1'b0;
  logic [31:0] InData = '0;

  logic [2:0]       InReady, RegWrite, Done, Busy;
  logic [2:0][4:0]  WordCount;
  logic [31:0]      wd [3][16];

  int     n_vec = 0;
  int     n_miss = 0;
  int     cyc = 0;
  frame_t sb [$];
  int     rw_cyc [3];
  bit     pend [3];
  int     rw_cnt [3];
  int     dn_cnt [3];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // k=0: GAP_CYCLES=1 (main, data checked); k=1: GAP 0; k=2: GAP 7
  thread_reg_loader #(.GAP_CYCLES(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Abort(Abort), .InData(InData),
    .InValid(InValid), .InReady(InReady[0]),
    .WriteData1(wd[0][0]),   .WriteData2(wd[0][1]),   .WriteData3(wd[0][2]),   .WriteData4(wd[0][3]),
    .WriteData5(wd[0][4]),   .WriteData6(wd[0][5]),   .WriteData7(wd[0][6]),   .WriteData8(wd[0][7]),
    .WriteData9(wd[0][8]),   .WriteData10(wd[0][9]),  .WriteData11(wd[0][10]), .WriteData12(wd[0][11]),
    .WriteData13(wd[0][12]), .WriteData14(wd[0][13]), .WriteData15(wd[0][14]), .WriteData16(wd[0][15]),
    .RegWrite(RegWrite[0]), .Done(Done[0]), .Busy(Busy[0]), .WordCount(WordCount[0])
  );

  thread_reg_loader #(.GAP_CYCLES(0)) u_dut_g0 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start_aux), .Abort(Abort), .InData(InData),
    .InValid(InValid), .InReady(InReady[1]),
    .WriteData1(wd[1][0]),   .WriteData2(wd[1][1]),   .WriteData3(wd[1][2]),   .WriteData4(wd[1][3]),
    .WriteData5(wd[1][4]),   .WriteData6(wd[1][5]),   .WriteData7(wd[1][6]),   .WriteData8(wd[1][7]),
    .WriteData9(wd[1][8]),   .WriteData10(wd[1][9]),  .WriteData11(wd[1][10]), .WriteData12(wd[1][11]),
    .WriteData13(wd[1][12]), .WriteData14(wd[1][13]), .WriteData15(wd[1][14]), .WriteData16(wd[1][15]),
    .RegWrite(RegWrite[1]), .Done(Done[1]), .Busy(Busy[1]), .WordCount(WordCount[1])
  );

  thread_reg_loader #(.GAP_CYCLES(7)) u_dut_g7 (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start_aux), .Abort(Abort), .InData(InData),
    .InValid(InValid), .InReady(InReady[2]),
    .WriteData1(wd[2][0]),   .WriteData2(wd[2][1]),   .WriteData3(wd[2][2]),   .WriteData4(wd[2][3]),
    .WriteData5(wd[2][4]),   .WriteData6(wd[2][5]),   .WriteData7(wd[2][6]),   .WriteData8(wd[2][7]),
    .WriteData9(wd[2][8]),   .WriteData10(wd[2][9]),  .WriteData11(wd[2][10]), .WriteData12(wd[2][11]),
    .WriteData13(wd[2][12]), .WriteData14(wd[2][13]), .WriteData15(wd[2][14]), .WriteData16(wd[2][15]),
    .RegWrite(RegWrite[2]), .Done(Done[2]), .Busy(Busy[2]), .WordCount(WordCount[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Commit monitor: frame contents against the scoreboard (main DUT),
  // Done spacing after RegWrite for every DUT.
  always @(negedge Clk) begin
    if (Rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (RegWrite[k]) begin
          rw_cnt[k]++;
          rw_cyc[k] = cyc;
          pend[k]   = 1'b1;
        end
        if (Done[k]) begin
          chk($sformatf("done_after_rw%0d", k), 32'(pend[k]), 32'd1);
          chk($sformatf("done_gap%0d", k), cyc - rw_cyc[k], GAPS[k] + 1);
          pend[k] = 1'b0;
          dn_cnt[k]++;
        end
      end
      if (RegWrite[0]) begin
        if (sb.size() == 0) begin
          chk("spurious_regwrite", 32'd1, 32'd0);
        end else begin
          frame_t f;
          f = sb.pop_front();
          for (int i = 0; i < 16; i++)
            chk($sformatf("wd%0d", i + 1), wd[0][i], f[i]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (Busy != 3'b000 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_timeout", 32'(Busy), 32'd0);
    tick();
  endtask

  // Start plus 16 words; optional bubble before each word; optional Start
  // re-assertion alongside word index start_at. Returns in the COMMIT cycle.
  task automatic run_frame(input logic [31:0] base, input bit bubbles,
                           input int start_at, input int exp_lat);
    frame_t f;
    int     s;
    for (int i = 0; i < 16; i++) f[i] = base + i;
    sb.push_back(f);
    Start = 1'b1; Start_aux = 1'b1;
    tick();
    Start = 1'b0; Start_aux = 1'b0;
    s = cyc;
    chk("start_wc", 32'(WordCount[0]), 32'd0);
    chk("start_rdy", 32'(InReady[0]), 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (bubbles) begin
        InValid = 1'b0;
        tick();
        chk("bubble_wc", 32'(WordCount[0]), i);
      end
      InValid = 1'b1;
      InData  = base + i;
      if (i == start_at) begin Start = 1'b1; Start_aux = 1'b1; end
      tick();
      Start = 1'b0; Start_aux = 1'b0;
      chk("wc", 32'(WordCount[0]), i + 1);
      chk("rw_only_at_16", 32'(RegWrite[0]), (i == 15) ? 32'd1 : 32'd0);
    end
    InValid = 1'b0;
    chk("rdy_after_16", 32'(InReady[0]), 32'd0);
    chk("latency", cyc - s + 1, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, no clock dependence
    #2;
    chk("rst_wc", 32'(WordCount[0]), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_rdy", 32'(InReady), 32'd0);
    chk("rst_rw", 32'(RegWrite), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_wd1", wd[0][0], 32'd0);
    chk("rst_wd16", wd[0][15], 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    tick();

    // Back-to-back frame
    run_frame(32'h100, 1'b0, -1, 17);
    wait_idle();
    chk("hold_wd1", wd[0][0], 32'h100);
    chk("hold_wd16", wd[0][15], 32'h10F);

    // Same frame with InValid toggling
    run_frame(32'h100, 1'b1, -1, 33);
    wait_idle();

    // Abort after 7 words; the coincident 8th word must be dropped
    Start = 1'b1; Start_aux = 1'b1;
    tick();
    Start = 1'b0; Start_aux = 1'b0;
    for (int i = 0; i < 7; i++) begin
      InValid = 1'b1; InData = 32'h300 + i;
      tick();
    end
    InData = 32'hDEAD; Abort = 1'b1;
    tick();
    Abort = 1'b0; InValid = 1'b0;
    chk("abort_wc", 32'(WordCount[0]), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_rdy", 32'(InReady[0]), 32'd0);
    chk("abort_wd1", wd[0][0], 32'h300);
    chk("abort_wd7", wd[0][6], 32'h306);
    chk("abort_wd8", wd[0][7], 32'h107);
    for (int i = 0; i < 4; i++) tick();
    run_frame(32'h400, 1'b0, -1, 17);
    wait_idle();

    // Start during FILL ignored; Abort in COMMIT ignored; Start in GAP ignored
    run_frame(32'h500, 1'b0, 4, 17);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    chk("gap_busy", 32'(Busy[0]), 32'd1);
    chk("gap_rw", 32'(RegWrite[0]), 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("gap_exit_busy", 32'(Busy[0]), 32'd0);
    chk("gap_exit_done", 32'(Done[0]), 32'd1);
    chk("gap_exit_wc", 32'(WordCount[0]), 32'd0);
    wait_idle();

    // Reset after 10 words, released between clock edges
    Start = 1'b1; Start_aux = 1'b1;
    tick();
    Start = 1'b0; Start_aux = 1'b0;
    for (int i = 0; i < 10; i++) begin
      InValid = 1'b1; InData = 32'h700 + i;
      tick();
    end
    InValid = 1'b0;
    #1 Rst_n = 1'b0;
    #1;
    chk("arst_wc", 32'(WordCount[0]), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_rdy", 32'(InReady), 32'd0);
    chk("arst_wd1", wd[0][0], 32'd0);
    chk("arst_wd10", wd[0][9], 32'd0);
    #4 Rst_n = 1'b1;
    tick();
    run_frame(32'h600, 1'b0, -1, 17);
    wait_idle();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rw_count%0d", k), rw_cnt[k], 32'd5);
      chk($sformatf("done_count%0d", k), dn_cnt[k], 32'd5);
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
